// File: rtl/phy_pkg.sv
// Shared QPSK physical-layer definitions: frame constants, transmit states
// and the symbol-to-I/Q mapping used by both transmitter and receiver.
package phy_pkg;

  localparam int          SOF_SYMS = 26;
  localparam logic [25:0] SOF_I    = 26'h3278428;
  localparam logic [25:0] SOF_Q    = 26'h272d17d;

  typedef logic signed [11:0] sample_t;

  typedef struct packed {
    sample_t i;
    sample_t q;
  } iq_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SOF  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } tx_state_t;

  // bit1 = I sign, bit0 = Q sign; a set bit selects the negative amplitude
  function automatic iq_t qpsk_map(input logic [1:0] sym, input sample_t amp);
    iq_t r;
    r.i = sym[1] ? -amp : amp;
    r.q = sym[0] ? -amp : amp;
    return r;
  endfunction

endpackage

// File: rtl/symbol_mapper.sv
// Output sample register: captures the QPSK point (or zero) of a new symbol
// at each symbol start and holds it for the rest of the symbol.
module symbol_mapper
  import phy_pkg::*;
#(
  parameter sample_t AMP = 12'sd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        zero,
  input  logic [1:0]  sym,
  output logic [23:0] iq
);

  logic [23:0] iq_r;

  // Sample register, reloaded only when a new symbol starts
  always_ff @(posedge clk) begin
    if (!rst) begin
      iq_r <= 24'h000000;
    end else if (load) begin
      if (zero) begin
        iq_r <= 24'h000000;
      end else begin
        iq_r <= qpsk_map(sym, AMP);
      end
    end
  end

  assign iq = iq_r;

endmodule

// File: rtl/physical_transmitter.sv
// QPSK framer/modulator: SOF + DATA_SYMS data symbols + GAP_SYMS zero symbols,
// SPS rectangular samples per symbol. Define TX_IDLE_PRBS_EN for PRBS-7 idle fill.
module physical_transmitter
  import phy_pkg::*;
#(
  parameter int      SPS       = 8,
  parameter sample_t AMP       = 12'sd1024,
  parameter int      GAP_SYMS  = 4,
  parameter int      DATA_SYMS = 63
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [1:0]  in_data,
  output logic        in_ready,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [23:0] out_data,
  output logic        busy,
  output logic        underrun
);

  localparam int SAMP_W = $clog2(SPS);
  localparam int CNT_W  = 8;

  tx_state_t         state_r, state_s;
  logic [SAMP_W-1:0] samp_cnt_r;
  logic [CNT_W-1:0]  sym_cnt_r, sym_cnt_s;
  logic              buf_full_r, buf_full_s;
  logic [1:0]        buf_sym_r;
  logic              in_ready_r, out_valid_r, busy_r, underrun_r;
  logic              beat_s, boundary_s, load_s, drain_s, underrun_s, zero_s;
  logic [1:0]        sym_s;
  logic [4:0]        sof_idx_s;
  logic              fill_zero_s;
  logic [1:0]        fill_sym_s;

  assign beat_s     = out_valid_r & out_ready;
  assign boundary_s = beat_s & (samp_cnt_r == SAMP_W'(SPS - 1));
  assign load_s     = in_valid & in_ready_r;
  assign buf_full_s = load_s | (buf_full_r & ~drain_s);

`ifdef TX_IDLE_PRBS_EN
  logic [6:0] lfsr_r, lfsr_s, lfsr_mid_s;
  logic       prbs_b1_s, prbs_b2_s;

  // Two x^7+x^6+1 steps per symbol, one output bit per step
  always_comb begin
    prbs_b1_s  = lfsr_r[6] ^ lfsr_r[5];
    lfsr_mid_s = {lfsr_r[5:0], prbs_b1_s};
    prbs_b2_s  = lfsr_mid_s[6] ^ lfsr_mid_s[5];
    lfsr_s     = {lfsr_mid_s[5:0], prbs_b2_s};
  end

  // LFSR state, advanced only when a fill symbol is issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      lfsr_r <= 7'h7F;
    end else if (boundary_s && (state_s == IDLE || state_s == GAP)) begin
      lfsr_r <= lfsr_s;
    end
  end

  assign fill_zero_s = 1'b0;
  assign fill_sym_s  = {prbs_b1_s, prbs_b2_s};
`else
  assign fill_zero_s = 1'b1;
  assign fill_sym_s  = 2'b00;
`endif

  // Next state and the symbol carried by the next SPS samples
  always_comb begin
    state_s    = state_r;
    sym_cnt_s  = sym_cnt_r;
    sym_s      = 2'b00;
    zero_s     = 1'b1;
    drain_s    = 1'b0;
    underrun_s = 1'b0;
    sof_idx_s  = 5'd0;
    if (boundary_s) begin
      case (state_r)
        IDLE: begin
          if (buf_full_r) begin
            state_s   = SOF;
            sym_cnt_s = '0;
          end else begin
            state_s   = IDLE;
          end
        end
        SOF: begin
          if (sym_cnt_r == CNT_W'(SOF_SYMS - 1)) begin
            state_s   = DATA;
            sym_cnt_s = '0;
          end else begin
            sym_cnt_s = sym_cnt_r + 8'd1;
          end
        end
        DATA: begin
          if (sym_cnt_r == CNT_W'(DATA_SYMS - 1)) begin
            state_s   = (GAP_SYMS == 0) ? IDLE : GAP;
            sym_cnt_s = '0;
          end else begin
            sym_cnt_s = sym_cnt_r + 8'd1;
          end
        end
        GAP: begin
          if (sym_cnt_r == CNT_W'(GAP_SYMS - 1)) begin
            state_s   = IDLE;
            sym_cnt_s = '0;
          end else begin
            sym_cnt_s = sym_cnt_r + 8'd1;
          end
        end
        default: begin
          state_s   = IDLE;
          sym_cnt_s = '0;
        end
      endcase

      case (state_s)
        SOF: begin
          // SOF constants are sent MSB first; a constant 1 is the positive point
          sof_idx_s = 5'd25 - sym_cnt_s[4:0];
          sym_s     = {~SOF_I[sof_idx_s], ~SOF_Q[sof_idx_s]};
          zero_s    = 1'b0;
        end
        DATA: begin
          drain_s    = buf_full_r;
          underrun_s = ~buf_full_r;
          zero_s     = ~buf_full_r;
          sym_s      = buf_sym_r;
        end
        IDLE, GAP: begin
          zero_s = fill_zero_s;
          sym_s  = fill_sym_s;
        end
        default: begin
          zero_s = 1'b1;
          sym_s  = 2'b00;
        end
      endcase
    end else begin
      state_s   = state_r;
      sym_cnt_s = sym_cnt_r;
    end
  end

  // Framing state, counters and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= IDLE;
      sym_cnt_r   <= '0;
      samp_cnt_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      sym_cnt_r   <= sym_cnt_s;
      out_valid_r <= 1'b1;
      busy_r      <= (state_s != IDLE);
      underrun_r  <= underrun_s;
      if (boundary_s) begin
        samp_cnt_r <= '0;
      end else if (beat_s) begin
        samp_cnt_r <= samp_cnt_r + SAMP_W'(1);
      end
    end
  end

  // One-entry input buffer; in_ready mirrors its next emptiness
  always_ff @(posedge clk) begin
    if (!rst) begin
      buf_full_r <= 1'b0;
      buf_sym_r  <= 2'b00;
      in_ready_r <= 1'b0;
    end else begin
      buf_full_r <= buf_full_s;
      in_ready_r <= ~buf_full_s;
      if (load_s) begin
        buf_sym_r <= in_data;
      end
    end
  end

  symbol_mapper #(
    .AMP (AMP)
  ) u_mapper (
    .clk  (clk),
    .rst  (rst),
    .load (boundary_s),
    .zero (zero_s),
    .sym  (sym_s),
    .iq   (out_data)
  );

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign underrun  = underrun_r;

endmodule

// File: tb/tb_physical_transmitter.sv
// Self-checking bench for physical_transmitter: randomized symbols/backpressure
// against a slot-queue reference model of the frame layout.
module tb_physical_transmitter;

  localparam int SPS       = 8;
  localparam int GAP_SYMS  = 4;
  localparam int DATA_SYMS = 63;
  localparam int ZERO      = -1;
  localparam int DSLOT     = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  in_data = 2'b00;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy, underrun;
  logic [23:0] out_data;

  physical_transmitter #(
    .SPS       (SPS),
    .GAP_SYMS  (GAP_SYMS),
    .DATA_SYMS (DATA_SYMS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [25:0] sof_i = 26'h3278428;
  logic [25:0] sof_q = 26'h272d17d;

  logic [1:0] txq[$];
  int vrate = 100;
  int rrate = 100;
  int busy_beats = 0;
  int under_cnt = 0;

  // reference model: queue of upcoming symbol slots for the current frame
  int          plan[$];
  bit          m_valid, m_busy, m_under, m_buf_full, m_in_ready;
  logic [1:0]  m_buf_sym;
  logic [23:0] m_data;
  int          m_phase;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] map2(input logic [1:0] s);
    return {(s[1] ? 12'hC00 : 12'h400), (s[0] ? 12'hC00 : 12'h400)};
  endfunction

  task automatic model_edge(input bit r, input bit iv, input logic [1:0] id, input bit ordy,
                            output bit load);
    bit drain;
    int code;
    load  = 1'b0;
    drain = 1'b0;
    if (!r) begin
      plan.delete();
      m_valid = 0; m_busy = 0; m_under = 0; m_buf_full = 0; m_in_ready = 0;
      m_buf_sym = 2'b00; m_data = 24'h0; m_phase = 0;
      return;
    end
    load    = iv && m_in_ready;
    m_under = 1'b0;
    if (m_valid && ordy) begin
      if (m_phase == SPS - 1) begin
        m_phase = 0;
        if (plan.size() == 0 && !m_busy && m_buf_full) begin
          for (int k = 0; k < 26; k++) plan.push_back(int'({~sof_i[25-k], ~sof_q[25-k]}));
          repeat (DATA_SYMS) plan.push_back(DSLOT);
          repeat (GAP_SYMS) plan.push_back(ZERO);
        end
        if (plan.size() == 0) begin
          m_busy = 1'b0;
          m_data = 24'h0;
        end else begin
          code   = plan.pop_front();
          m_busy = 1'b1;
          if (code == DSLOT) begin
            if (m_buf_full) begin
              drain  = 1'b1;
              m_data = map2(m_buf_sym);
            end else begin
              m_under = 1'b1;
              m_data  = 24'h0;
            end
          end else if (code == ZERO) begin
            m_data = 24'h0;
          end else begin
            m_data = map2(code[1:0]);
          end
        end
      end else begin
        m_phase++;
      end
    end
    if (load) begin
      m_buf_full = 1'b1;
      m_buf_sym  = id;
    end else if (drain) begin
      m_buf_full = 1'b0;
    end
    m_in_ready = !m_buf_full;
    m_valid    = 1'b1;
  endtask

  task automatic step();
    bit ld;
    @(negedge clk);
    in_valid  = (txq.size() > 0) && ($urandom_range(0, 99) < vrate);
    in_data   = (txq.size() > 0) ? txq[0] : 2'b00;
    out_ready = ($urandom_range(0, 99) < rrate);
    if (busy && out_valid && out_ready) busy_beats++;
    model_edge(rst, in_valid, in_data, out_ready, ld);
    if (ld) void'(txq.pop_front());
    @(posedge clk);
    #1;
    if (underrun) under_cnt++;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    chk("out_data", {8'd0, out_data}, {8'd0, m_data});
    chk("busy", {31'd0, busy}, {31'd0, m_busy});
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("underrun", {31'd0, underrun}, {31'd0, m_under});
  endtask

  task automatic frame_start(input string tag);
    int n = 0;
    busy_beats = 0;
    under_cnt  = 0;
    while (!busy && n < 2000) begin step(); n++; end
    chk({tag, "_start"}, {31'd0, busy}, 32'd1);
    chk({tag, "_sof0"}, {8'd0, out_data}, 32'h00400400);
  endtask

  task automatic frame_end(input string tag, input int exp_under);
    int n = 0;
    while (busy && n < 6000) begin step(); n++; end
    chk({tag, "_end"}, {31'd0, busy}, 32'd0);
    chk({tag, "_beats"}, busy_beats, (26 + DATA_SYMS + GAP_SYMS) * SPS);
    if (exp_under >= 0) chk({tag, "_under"}, under_cnt, exp_under);
  endtask

  initial begin
    int nz, seen;
    logic [23:0] held;

    rst = 1'b0;
    repeat (3) step();
    chk("rst_out_data", {8'd0, out_data}, 32'd0);
    rst = 1'b1;

    nz = 0;
    repeat (100) begin
      step();
      if (out_data !== 24'h0) nz++;
    end
    chk("idle_zero", nz, 0);
    chk("idle_valid", {31'd0, out_valid}, 32'd1);
    chk("idle_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    repeat (DATA_SYMS) txq.push_back(2'b00);
    frame_start("b2b");
    frame_end("b2b", 0);

    for (int i = 0; i < DATA_SYMS; i++) txq.push_back(i[1:0]);
    frame_start("seq");
    frame_end("seq", 0);

    repeat (10) txq.push_back(2'($urandom_range(0, 3)));
    frame_start("starve");
    frame_end("starve", DATA_SYMS - 10);

    repeat (DATA_SYMS) txq.push_back(2'($urandom_range(0, 3)));
    frame_start("hold");
    repeat (250) step();
    held  = out_data;
    rrate = 0;
    repeat (5) begin
      step();
      chk("hold_data", {8'd0, out_data}, {8'd0, held});
    end
    rrate = 100;
    frame_end("hold", 0);

    vrate = 70;
    rrate = 60;
    repeat (2 * DATA_SYMS) txq.push_back(2'($urandom_range(0, 3)));
    frame_start("rand1");
    frame_end("rand1", -1);
    frame_start("rand2");
    frame_end("rand2", -1);
    vrate = 100;
    rrate = 100;
    txq.delete();

    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    step();
    txq.push_back(2'b11);
    frame_start("rstmid");
    repeat (10) step();
    rst = 1'b0;
    step();
    chk("rstmid_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_ready", {31'd0, in_ready}, 32'd0);
    rst  = 1'b1;
    seen = 0;
    repeat (300) begin
      step();
      if (busy) seen++;
    end
    chk("rstmid_no_replay", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/physical_transmitter.md
Name: physical_transmitter

Overview:
- QPSK baseband framer and modulator; the transmit counterpart of the physical receiver.
- Accepts 2-bit symbols from the link layer and builds frames of a 26-symbol SOF followed by 63 data symbols.
- Outputs rectangular-pulse I/Q samples, SPS samples per symbol, to the DAC/RF stream in the receiver's {I[11:0],Q[11:0]} format.

Parameters:
- SPS, 8, samples per symbol; power of two, 2..16.
- AMP, 12'sd1024, signed magnitude driven on I and Q.
- GAP_SYMS, 4, zero-amplitude symbols inserted after every frame (0 allowed).
- DATA_SYMS, 63, data symbols per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-low; reset is applied when rst==0 at a clk edge.
- in_valid  in  1  input symbol valid.
- in_data  in  2  symbol; bit1 = I sign, bit0 = Q sign (1 = negative).
- in_ready  out  1  symbol accepted when in_valid & in_ready.
- out_ready  in  1  DAC accepts a sample.
- out_valid  out  1  sample valid.
- out_data  out  24  {I[11:0],Q[11:0]}, two's complement.
- busy  out  1  high while state != IDLE.
- underrun  out  1  one-cycle pulse when a data symbol slot finds the buffer empty.

Behaviour:
- Reset values: out_valid=0, out_data=0, in_ready=0, busy=0, underrun=0; state=IDLE; all counters 0; buffer empty.
- The output stream is continuous after reset: out_valid=1 from the first cycle after rst deasserts. A sample advances only on out_valid&out_ready; with out_ready low, out_data and all counters hold.
- Input buffer: one symbol register. in_ready = ~buf_full (registered, 0 during reset). A simultaneous load and drain in one cycle is allowed and keeps the buffer full.
- Counters:
  - samp_cnt: 0..SPS-1, advances per output beat.
  - sym_cnt: counts symbols within the current state.
  - A symbol boundary occurs on a beat with samp_cnt==SPS-1.
- Mapping: I = bit1 ? -AMP : +AMP; Q = bit0 ? -AMP : +AMP. Symbol 00 gives (+,+), 01 gives (+,-), 10 gives (-,+), 11 gives (-,-). Zero symbol gives I=Q=0.
- IDLE:
  - Emits zero samples.
  - At a symbol boundary, if buf_full, go to SOF with sym_cnt=0. The buffer is not consumed.
- SOF:
  - Symbol k (0..25) uses I sign = ~SOF_I[25-k] and Q sign = ~SOF_Q[25-k] (constant bit 1 means positive).
  - SOF_I = 26'h3278428, SOF_Q = 26'h272d17d, sent MSB first.
  - After symbol 25, go to DATA.
- DATA:
  - At each symbol start, drain the buffer and map the symbol.
  - If the buffer is empty, send a zero symbol, pulse underrun for one cycle, and still count the slot.
  - After DATA_SYMS symbols, go to GAP, or to IDLE if GAP_SYMS==0.
- GAP: GAP_SYMS zero symbols, then IDLE.
- State changes and new symbol values take effect only on symbol boundaries; there are no partial symbols.
- Latency: the first SOF sample appears on out_data at the first boundary after the buffer fills. Worst case is SPS beats after the load.
- Reset mid-frame: immediate return to reset values. The buffered symbol is discarded and no partial frame completes.

Optional Feature:
- Macro TX_IDLE_PRBS_EN.
- Defined: IDLE and GAP transmit a PRBS-7 symbol stream (x^7+x^6+1, seed 7'h7F, 2 bits per symbol taken from consecutive LFSR steps) at full amplitude. This keeps the receiver's Gardner loop locked between frames. The LFSR advances only on symbol boundaries and resets to the seed.
- Undefined: IDLE and GAP emit zeros, and no LFSR logic is present.

Decomposition:
- Package phy_pkg holds:
  - SOF_I and SOF_Q constants;
  - the tx_state_t enum {IDLE, SOF, DATA, GAP};
  - a qpsk_map function (2-bit symbol to signed I/Q pair);
  - the sample_t typedef (12-bit signed).
  - The receiver shares these constants.
- One sub-module, symbol_mapper: registered symbol/zero-select to {I,Q} mapping. The PRBS generator lives inline under the macro.

Test Plan:
- Reset then idle, out_ready=1, no input: out_valid=1, out_data=24'h0 for 100 beats; busy=0, in_ready=1.
- Load 63 symbols of 2'b00 back-to-back:
  - 26*8 SOF samples; the first SOF symbol has I=+1024 (bit25 of 3278428 is 1) and Q=+1024;
  - then 504 samples of {12'd1024,12'd1024};
  - then 32 zero samples; busy then drops.
- Data sequence 00,01,10,11 repeated: each 8-sample run maps to (+,+), (+,-), (-,+), (-,-) with 12'hC00 for -1024; no underrun.
- Stop input after 10 data symbols: slots 11..63 are zero, with 53 underrun pulses; the frame still ends on schedule.
- Hold out_ready=0 for 5 cycles mid-symbol: out_data is frozen and the symbol still spans exactly 8 accepted beats.
- Assert rst=0 during the SOF: the next cycle shows out_valid=0, busy=0, in_ready=0. After release, the previously loaded symbol is not transmitted.
